// File: rtl/initial_logic_pkg.sv
// Shared types and defaults for the N-VC initial logic demux.
// Optional bypass feature: INITIAL_LOGIC_BYPASS_EN.
package initial_logic_pkg;

  localparam int DATA_WIDTH_DEF = 6;
  localparam int VC_SEL_W_DEF   = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  function automatic logic [VC_SEL_W_DEF-1:0] vc_sel(
    input logic [DATA_WIDTH_DEF-1:0] word
  );
    return word[DATA_WIDTH_DEF-1 -: VC_SEL_W_DEF];
  endfunction

endpackage

// File: rtl/initial_logic_nvc_buffer.sv
// Input FIFO for initial_logic_nvc: storage, pointers, count, flags.
// Optional bypass feature (in top): INITIAL_LOGIC_BYPASS_EN.
module il_buffer #(
  parameter int DW = 6,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty,
  output logic          last,
  output logic          overflow
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          accept;
  logic          do_pop;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign last   = (count == ONE_CNT);
  assign head   = mem[rd_ptr];
  assign accept = wr && !full;
  assign do_pop = pop && !empty;

  // storage write, no reset needed on data
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= din;
  end

  // pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (accept && !do_pop) count <= count + ONE_CNT;
      if (!accept && do_pop) count <= count - ONE_CNT;
      if (wr && full) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/initial_logic_nvc.sv
// Transmit-side demux: input FIFO routed to NUM_VC channel FIFOs.
// Optional 1-cycle bypass when idle: INITIAL_LOGIC_BYPASS_EN.
module initial_logic_nvc
  import initial_logic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int VC_SEL_W   = VC_SEL_W_DEF,
  parameter int ADDR_WIDTH = 2,
  localparam int NUM_VC    = 1 << VC_SEL_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [NUM_VC-1:0]     pause_vc,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [NUM_VC-1:0]     push_vc,
  output logic                  buf_full,
  output logic                  buf_empty,
  output logic                  overflow
);

  localparam logic [NUM_VC-1:0] ONE_HOT0 = NUM_VC'(1);

  state_t state;
  state_t state_nx;

  logic [DATA_WIDTH-1:0] head;
  logic [VC_SEL_W-1:0]   sel_head;
  logic                  last;
  logic                  pop;
  logic                  bypass;
  logic                  buf_wr;
  logic                  buf_acc;

  assign sel_head = head[DATA_WIDTH-1 -: VC_SEL_W];

  il_buffer #(
    .DW (DATA_WIDTH),
    .AW (ADDR_WIDTH)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .wr       (buf_wr),
    .din      (data_in),
    .pop      (pop),
    .head     (head),
    .full     (buf_full),
    .empty    (buf_empty),
    .last     (last),
    .overflow (overflow)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next state: leave IDLE on a buffered word, return when drained
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (buf_acc) state_nx = ACTIVE;
      ACTIVE: if (pop && last && !buf_acc) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // pop / bypass / buffer-write decisions
  always_comb begin
    pop = (state == ACTIVE) && !buf_empty && !pause_vc[sel_head];
`ifdef INITIAL_LOGIC_BYPASS_EN
    bypass = (state == IDLE) && wr_enable &&
             !pause_vc[data_in[DATA_WIDTH-1 -: VC_SEL_W]];
`else
    bypass = 1'b0;
`endif
    buf_wr  = wr_enable && !bypass;
    buf_acc = buf_wr && !buf_full;
  end

  // registered push toward the VC FIFOs
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
      push_vc  <= '0;
    end else begin
      data_out <= '0;
      push_vc  <= '0;
      unique case (1'b1)
        pop: begin
          data_out <= head;
          push_vc  <= ONE_HOT0 << sel_head;
        end
        bypass: begin
          data_out <= data_in;
          push_vc  <= ONE_HOT0 << data_in[DATA_WIDTH-1 -: VC_SEL_W];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_initial_logic_nvc.sv
// Self-checking bench for initial_logic_nvc: queue model + directed checks.
// Bypass expectations follow INITIAL_LOGIC_BYPASS_EN.
module tb_initial_logic_nvc;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_enable;
  logic [5:0] data_in;
  logic [3:0] pause_vc;
  logic [5:0] data_out;
  logic [3:0] push_vc;
  logic       buf_full;
  logic       buf_empty;
  logic       overflow;

  int checks = 0;
  int passes = 0;

`ifdef INITIAL_LOGIC_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  initial_logic_nvc #(
    .DATA_WIDTH (6),
    .VC_SEL_W   (2),
    .ADDR_WIDTH (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_enable (wr_enable),
    .data_in   (data_in),
    .pause_vc  (pause_vc),
    .data_out  (data_out),
    .push_vc   (push_vc),
    .buf_full  (buf_full),
    .buf_empty (buf_empty),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // behavioural model: a plain word queue of depth 4
  logic [5:0] q[$];
  bit         m_ovf;
  bit         armed = 1'b0;
  logic [5:0] e_d;
  logic [3:0] e_p;
  bit         m_pop;
  bit         m_byp;
  logic [1:0] vsel;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_ovf = 1'b0;
      e_d   = '0;
      e_p   = '0;
      armed = 1'b1;
    end else begin
      m_pop = 1'b0;
      if (q.size() > 0) begin
        vsel  = q[0][5:4];
        m_pop = !pause_vc[vsel];
      end
      vsel  = data_in[5:4];
      m_byp = BYP && q.size() == 0 && wr_enable && !pause_vc[vsel];
      e_d = '0;
      e_p = '0;
      if (m_pop) begin
        e_d = q[0];
        vsel = q[0][5:4];
        e_p = 4'b0001 << vsel;
      end else if (m_byp) begin
        e_d = data_in;
        e_p = 4'b0001 << vsel;
      end
      if (wr_enable && !m_byp) begin
        if (q.size() < 4) begin
          if (m_pop) void'(q.pop_front());
          q.push_back(data_in);
        end else begin
          if (m_pop) void'(q.pop_front());
          m_ovf = 1'b1;
        end
      end else if (m_pop) begin
        void'(q.pop_front());
      end
    end
    #1;
    if (armed) begin
      chk("m_data", {2'b0, data_out}, {2'b0, e_d});
      chk("m_push", {4'b0, push_vc}, {4'b0, e_p});
      chk("m_full", {7'b0, buf_full}, {7'b0, q.size() == 4});
      chk("m_empty", {7'b0, buf_empty}, {7'b0, q.size() == 0});
      chk("m_ovf", {7'b0, overflow}, {7'b0, m_ovf});
    end
  end

  task automatic cyc(input bit r, input bit w, input logic [5:0] d,
                     input logic [3:0] p);
    @(negedge clk);
    reset     = r;
    wr_enable = w;
    data_in   = d;
    pause_vc  = p;
  endtask

  task automatic out_is(input string n, input logic [5:0] d,
                        input logic [3:0] p);
    chk({n, "_data"}, {2'b0, data_out}, {2'b0, d});
    chk({n, "_push"}, {4'b0, push_vc}, {4'b0, p});
  endtask

  initial begin
    reset = 1'b1; wr_enable = 1'b0; data_in = '0; pause_vc = '0;
    // 1: reset
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    out_is("rst", 6'h00, 4'b0000);
    chk("rst_empty", {7'b0, buf_empty}, 8'h01);
    chk("rst_full", {7'b0, buf_full}, 8'h00);
    chk("rst_ovf", {7'b0, overflow}, 8'h00);
    // 2: streaming, one per VC
    cyc(0, 1, 6'h05, 0);
    cyc(0, 1, 6'h1A, 0);
    out_is("s0", 6'h00, 4'b0000);
    cyc(0, 1, 6'h2B, 0);
    out_is("s1", 6'h05, 4'b0001);
    cyc(0, 1, 6'h3C, 0);
    out_is("s2", 6'h1A, 4'b0010);
    cyc(0, 0, 0, 0);
    out_is("s3", 6'h2B, 4'b0100);
    cyc(0, 0, 0, 0);
    out_is("s4", 6'h3C, 4'b1000);
    cyc(0, 0, 0, 0);
    out_is("s5", 6'h00, 4'b0000);
    // 3: head-of-line blocking
    cyc(0, 1, 6'h11, 4'b0010);
    cyc(0, 1, 6'h02, 4'b0010);
    cyc(0, 0, 0, 4'b0010);
    cyc(0, 0, 0, 4'b0010);
    out_is("hol_blk", 6'h00, 4'b0000);
    cyc(0, 0, 0, 4'b0000);
    out_is("hol_rel", 6'h00, 4'b0000);
    cyc(0, 0, 0, 0);
    out_is("hol_a", 6'h11, 4'b0010);
    cyc(0, 0, 0, 0);
    out_is("hol_b", 6'h02, 4'b0001);
    cyc(0, 0, 0, 0);
    // 4: fill, overflow, drain
    for (int i = 0; i < 5; i++) cyc(0, 1, 6'(i), 4'hF);
    chk("ov_full4", {7'b0, buf_full}, 8'h01);
    chk("ov_pre", {7'b0, overflow}, 8'h00);
    cyc(0, 0, 0, 4'hF);
    chk("ov_set", {7'b0, overflow}, 8'h01);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0);
      out_is("ov_drain", 6'(i), 4'b0001);
    end
    cyc(0, 0, 0, 0);
    out_is("ov_end", 6'h00, 4'b0000);
    chk("ov_sticky", {7'b0, overflow}, 8'h01);
    // 5: reset discards buffered words
    cyc(0, 1, 6'h01, 4'hF);
    cyc(0, 1, 6'h02, 4'hF);
    cyc(0, 1, 6'h03, 4'hF);
    cyc(1, 0, 0, 4'hF);
    cyc(0, 0, 0, 0);
    out_is("mr", 6'h00, 4'b0000);
    chk("mr_empty", {7'b0, buf_empty}, 8'h01);
    chk("mr_ovf", {7'b0, overflow}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0);
      chk("mr_nopush", {4'b0, push_vc}, 8'h00);
    end
    // 6: bypass path (or normal latency without it)
    cyc(0, 1, 6'h25, 0);
    cyc(0, 0, 0, 0);
    if (BYP) out_is("bp1", 6'h25, 4'b0100);
    else     out_is("bp1", 6'h00, 4'b0000);
    cyc(0, 0, 0, 0);
    if (BYP) out_is("bp2", 6'h00, 4'b0000);
    else     out_is("bp2", 6'h25, 4'b0100);
    cyc(0, 1, 6'h25, 4'b0100);
    cyc(0, 0, 0, 4'b0100);
    out_is("bpp_hold", 6'h00, 4'b0000);
    cyc(0, 0, 0, 0);
    out_is("bpp_rel", 6'h00, 4'b0000);
    cyc(0, 0, 0, 0);
    out_is("bpp_push", 6'h25, 4'b0100);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
